// File: rtl/rs_alloc_unit.sv
// ============================================================================
//  Module      : rs_alloc_unit
//  Description : Reservation-station entry allocator. Tracks the busy vector,
//                selects up to two free entries per cycle, frees on issue and
//                clears the whole station on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_alloc_unit #(
    parameter int ENTNUM = 8,
    parameter int ENTSEL = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req1,
    input  logic              req2,
    input  logic [1:0]        reqnum,
    input  logic              dispatch_valid,
    input  logic              issue_valid,
    input  logic [ENTSEL-1:0] issue_ent,
    input  logic              flush,
    output logic              allocatable,
    output logic [ENTSEL-1:0] alloc_ent1,
    output logic [ENTSEL-1:0] alloc_ent2,
    output logic [ENTNUM-1:0] busy_vec,
    output logic [ENTSEL:0]   free_cnt
);

    localparam logic [ENTSEL:0]   c_full_cnt = (ENTSEL+1)'(ENTNUM);
    localparam logic [ENTNUM-1:0] c_one_hot0 = ENTNUM'(1);

    logic [ENTSEL-1:0] w_f0;
    logic [ENTSEL-1:0] w_f1;
    logic [ENTNUM-1:0] w_alloc_mask;
    logic [ENTNUM-1:0] w_issue_mask;
    logic [ENTNUM-1:0] w_busy_next;
    logic [ENTSEL:0]   w_busy_pop;
    logic [ENTSEL:0]   w_free_next;
    logic              w_grant;

    // Lowest and second-lowest free index; both stay 0 when not present.
    always_comb begin
        int seen;
        w_f0 = '0;
        w_f1 = '0;
        seen = 0;
        for (int i = 0; i < ENTNUM; i++) begin
            if (!busy_vec[i]) begin
                if (seen == 0) begin
                    w_f0 = ENTSEL'(i);
                end else if (seen == 1) begin
                    w_f1 = ENTSEL'(i);
                end
                seen = seen + 1;
            end
        end
    end

    assign allocatable = (free_cnt >= (ENTSEL+1)'(reqnum));

    // A lone slot-2 request takes the lowest free entry.
    assign alloc_ent1 = w_f0;
    assign alloc_ent2 = (req2 && !req1) ? w_f0 : w_f1;

    assign w_grant = dispatch_valid && allocatable && !flush;

    always_comb begin
        w_alloc_mask = '0;
        if (w_grant) begin
            if (req1) begin
                w_alloc_mask = w_alloc_mask | (c_one_hot0 << alloc_ent1);
            end
            if (req2) begin
                w_alloc_mask = w_alloc_mask | (c_one_hot0 << alloc_ent2);
            end
        end
    end

    assign w_issue_mask = issue_valid ? (c_one_hot0 << issue_ent) : '0;

    always_comb begin
        if (flush) begin
            w_busy_next = '0;
        end else begin
            w_busy_next = (busy_vec & ~w_issue_mask) | w_alloc_mask;
        end
    end

    always_comb begin
        w_busy_pop = '0;
        for (int i = 0; i < ENTNUM; i++) begin
            w_busy_pop = w_busy_pop + (ENTSEL+1)'(w_busy_next[i]);
        end
    end

    assign w_free_next = c_full_cnt - w_busy_pop;

    // Busy vector and free count update together so they never disagree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec <= '0;
            free_cnt <= c_full_cnt;
        end else begin
            busy_vec <= w_busy_next;
            free_cnt <= w_free_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_alloc_unit.sv
// ============================================================================
//  Module      : tb_rs_alloc_unit
//  Description : Self-checking bench for rs_alloc_unit against a free-list
//                reference model; directed scenarios then random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_alloc_unit;

    localparam int ENTNUM = 8;
    localparam int ENTSEL = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req1, req2;
    logic [1:0]        reqnum;
    logic              dispatch_valid;
    logic              issue_valid;
    logic [ENTSEL-1:0] issue_ent;
    logic              flush;
    logic              allocatable;
    logic [ENTSEL-1:0] alloc_ent1, alloc_ent2;
    logic [ENTNUM-1:0] busy_vec;
    logic [ENTSEL:0]   free_cnt;

    int total = 0;
    int bad   = 0;
    bit mb[ENTNUM];

    rs_alloc_unit #(.ENTNUM(ENTNUM), .ENTSEL(ENTSEL)) dut (
        .clk(clk), .reset_n(reset_n), .req1(req1), .req2(req2), .reqnum(reqnum),
        .dispatch_valid(dispatch_valid), .issue_valid(issue_valid),
        .issue_ent(issue_ent), .flush(flush), .allocatable(allocatable),
        .alloc_ent1(alloc_ent1), .alloc_ent2(alloc_ent2),
        .busy_vec(busy_vec), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: the station as an array of occupied flags.
    function automatic int m_free_cnt();
        int c = 0;
        foreach (mb[i]) if (!mb[i]) c++;
        return c;
    endfunction

    function automatic int m_nth_free(int n);
        int q[$];
        foreach (mb[i]) if (!mb[i]) q.push_back(i);
        return (n < q.size()) ? q[n] : 0;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        foreach (mb[i]) v[i] = mb[i];
        return v;
    endfunction

    function automatic void m_clear();
        foreach (mb[i]) mb[i] = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r1, input bit r2, input bit dv,
                         input bit iv, input int ie, input bit fl);
        req1           = r1;
        req2           = r2;
        reqnum         = 2'(r1) + 2'(r2);
        dispatch_valid = dv;
        issue_valid    = iv;
        issue_ent      = ENTSEL'(ie);
        flush          = fl;
    endtask

    task automatic check_comb(input string tag);
        int need;
        #1;
        need = int'(req1) + int'(req2);
        chk({tag, "_allocatable"}, 32'(allocatable), 32'(m_free_cnt() >= need));
        chk({tag, "_ent1"}, 32'(alloc_ent1), 32'(m_nth_free(0)));
        chk({tag, "_ent2"}, 32'(alloc_ent2),
            32'((req2 && !req1) ? m_nth_free(0) : m_nth_free(1)));
    endtask

    task automatic tick(input string tag);
        bit nb[ENTNUM];
        int need, p0, p1;
        nb   = mb;
        need = int'(req1) + int'(req2);
        p0   = m_nth_free(0);
        p1   = m_nth_free(1);
        if (flush) begin
            foreach (nb[i]) nb[i] = 1'b0;
        end else begin
            if (issue_valid) nb[issue_ent] = 1'b0;
            if (dispatch_valid && m_free_cnt() >= need) begin
                if (req1 && req2) begin
                    nb[p0] = 1'b1;
                    nb[p1] = 1'b1;
                end else if (req1 || req2) begin
                    nb[p0] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        mb = nb;
        chk({tag, "_busy"}, 32'(busy_vec), m_vec());
        chk({tag, "_free"}, 32'(free_cnt), 32'(m_free_cnt()));
        chk({tag, "_inv"}, 32'(free_cnt), 32'(ENTNUM - $countones(busy_vec)));
    endtask

    task automatic step(input string tag, input bit r1, input bit r2, input bit dv,
                        input bit iv, input int ie, input bit fl);
        drive(r1, r2, dv, iv, ie, fl);
        check_comb(tag);
        tick(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        m_clear();

        // T1 reset state
        #12;
        chk("t1_busy", 32'(busy_vec), 32'h00);
        chk("t1_free", 32'(free_cnt), 32'd8);
        chk("t1_alloc", 32'(allocatable), 32'd1);
        chk("t1_ent1", 32'(alloc_ent1), 32'd0);
        chk("t1_ent2", 32'(alloc_ent2), 32'd1);
        reset_n = 1'b1;

        // T2 dual allocation fills the station pairwise
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 0, 0, 0);
            #1;
            chk("t2_ent1", 32'(alloc_ent1), 32'(2 * k));
            chk("t2_ent2", 32'(alloc_ent2), 32'(2 * k + 1));
            tick("t2");
        end
        chk("t2_full_busy", 32'(busy_vec), 32'hFF);
        chk("t2_full_free", 32'(free_cnt), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("t2_full_alloc", 32'(allocatable), 32'd0);

        // T3 fragmentation: free entries 1 and 3
        step("t3_iss1", 0, 0, 0, 1, 1, 0);
        step("t3_iss3", 0, 0, 0, 1, 3, 0);
        chk("t3_f5", 32'(busy_vec), 32'hF5);
        drive(0, 1, 1, 0, 0, 0);
        #1;
        chk("t3_ent2", 32'(alloc_ent2), 32'd1);
        tick("t3_r2");
        chk("t3_f7", 32'(busy_vec), 32'hF7);
        drive(1, 1, 1, 0, 0, 0);
        #1;
        chk("t3_refuse", 32'(allocatable), 32'd0);
        tick("t3_refuse");
        chk("t3_unchanged", 32'(busy_vec), 32'hF7);

        // T4 issue and allocate in the same cycle on a full station
        step("t4_fill", 1, 0, 1, 0, 0, 0);
        chk("t4_ff", 32'(busy_vec), 32'hFF);
        drive(1, 0, 1, 1, 5, 0);
        #1;
        chk("t4_alloc0", 32'(allocatable), 32'd0);
        tick("t4_iss");
        chk("t4_df", 32'(busy_vec), 32'hDF);
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("t4_reuse", 32'(alloc_ent1), 32'd5);

        // T5 flush beats alloc and issue
        step("t5_flush0", 0, 0, 0, 0, 0, 1);
        step("t5_a", 1, 1, 1, 0, 0, 0);
        step("t5_b", 1, 1, 1, 0, 0, 0);
        chk("t5_0f", 32'(busy_vec), 32'h0F);
        step("t5_flush", 1, 1, 1, 1, 2, 1);
        chk("t5_busy", 32'(busy_vec), 32'h00);
        chk("t5_free", 32'(free_cnt), 32'd8);

        // T6 asynchronous reset between edges
        for (int k = 0; k < 3; k++) step("t6_alloc", 1, 0, 1, 0, 0, 0);
        chk("t6_pre", 32'(busy_vec), 32'h07);
        drive(1, 1, 1, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        m_clear();
        chk("t6_busy", 32'(busy_vec), 32'h00);
        chk("t6_free", 32'(free_cnt), 32'd8);
        #2;
        reset_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, ENTNUM - 1)), ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
